// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared width helpers and default parameters for the CIC integrator/comb chain
//
// clog2          : ceiling log2 (clog2(1) = 0)
// cic_acc_width  : Hogenauer register width DATA_WIDTH + N*clog2(R*M), shared by
//                  the integrator and comb instances so both ends agree
package cic_pkg;

    localparam int CIC_DATA_WIDTH = 12;
    localparam int CIC_N          = 3;
    localparam int CIC_R          = 4;
    localparam int CIC_M          = 1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int cic_acc_width(input int data_width, input int n, input int r, input int m);
        return data_width + n * clog2(r * m);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// rtl/cic_integrator.sv - one registered wrap-around integrator stage
//
// clk    : system clock
// rst_n  : asynchronous active-low reset, clears the accumulator
// clr    : synchronous clear, priority over en
// en     : accumulate d this edge
// d      : addend (sign-extended sample or previous stage's registered value)
// q      : accumulator value
module cic_integrator #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Modular add: overflow wrap is what makes the CIC work once the combs
    // take differences, so the carry out is deliberately discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + d;
        end
    end

endmodule

// File: rtl/cic_integrator_decimator.sv
// rtl/cic_integrator_decimator.sv - N cascaded integrators plus decimate-by-R output register
//
// clk        : system clock
// rst_n      : asynchronous active-low reset
// clr        : synchronous clear of accumulators, phase and pending output
// in_valid   : x is a valid input-rate sample
// x          : signed input sample
// out_valid  : one-cycle strobe, y holds a new decimated sample
// y          : signed decimated integrator output (feeds the comb chain)
// phase      : current decimation phase 0..R-1
module cic_integrator_decimator
    import cic_pkg::*;
#(
    parameter  int DATA_WIDTH = CIC_DATA_WIDTH,
    parameter  int N          = CIC_N,
    parameter  int R          = CIC_R,
    parameter  int M          = CIC_M,
    localparam int ACC_WIDTH  = cic_acc_width(DATA_WIDTH, N, R, M),
    localparam int PHASE_W    = clog2(R)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] x,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  y,
    output logic [PHASE_W-1:0]    phase
);

    logic [ACC_WIDTH-1:0] x_ext;
    logic [ACC_WIDTH-1:0] stage_in [N];
    logic [ACC_WIDTH-1:0] stage_q  [N];
    logic [ACC_WIDTH-1:0] last_next;
    logic                 last_phase;

    assign x_ext = {{(ACC_WIDTH - DATA_WIDTH){x[DATA_WIDTH-1]}}, x};

    // Each stage adds the previous stage's registered value, so the chain is
    // pipelined and there is no combinational path through the integrators.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_in[gi] = x_ext;
            end else begin : g_rest
                assign stage_in[gi] = stage_q[gi-1];
            end
            cic_integrator #(
                .WIDTH(ACC_WIDTH)
            ) u_integrator (
                .clk  (clk),
                .rst_n(rst_n),
                .clr  (clr),
                .en   (in_valid),
                .d    (stage_in[gi]),
                .q    (stage_q[gi])
            );
        end
    endgenerate

    // Value the last stage is about to be written with; the decimated output
    // captures this so y matches acc[N] as updated on the strobe edge.
    assign last_next  = stage_q[N-1] + stage_in[N-1];
    assign last_phase = (phase == PHASE_W'(R - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            phase     <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (last_phase) begin
                    phase     <= '0;
                    y         <= last_next;
                    out_valid <= 1'b1;
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_integrator_decimator.sv
// tb/tb_cic_integrator_decimator.sv - self-checking bench for cic_integrator_decimator
module tb_cic_integrator_decimator;

    localparam int  DW   = 12;
    localparam int  AW   = 18;
    localparam longint MASK = (64'd1 << AW) - 1;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic [DW-1:0] x;
    logic          out_valid;
    logic [AW-1:0] y;
    logic [1:0]    phase;

    int compared;
    int mismatched;
    int cyc;

    logic [AW-1:0] exp_q  [$];
    logic [AW-1:0] y_hist [$];
    int            strobe_cyc [$];

    longint macc [3];
    int     mphase;

    cic_integrator_decimator #(
        .DATA_WIDTH(12),
        .N         (3),
        .R         (4),
        .M         (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .x        (x),
        .out_valid(out_valid),
        .y        (y),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe pops one expected value pushed by the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            y_hist.push_back(y);
            strobe_cyc.push_back(cyc);
            compared = compared + 1;
            if (exp_q.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL unexpected_strobe: got y=%0d, required no strobe", y);
            end else begin
                logic [AW-1:0] e;
                e = exp_q.pop_front();
                if (y !== e) begin
                    mismatched = mismatched + 1;
                    $display("FAIL scoreboard_y: got %0d, required %0d", y, e);
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 3; i++) macc[i] = 0;
        mphase = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] xv);
        longint xs;
        xs = longint'($signed(xv));
        // Top stage first so each stage sees the previous stage's old value.
        macc[2] = (macc[2] + macc[1]) & MASK;
        macc[1] = (macc[1] + macc[0]) & MASK;
        macc[0] = (macc[0] + xs) & MASK;
        if (mphase == 3) exp_q.push_back(macc[2][AW-1:0]);
        mphase = (mphase + 1) % 4;
    endtask

    task automatic put(input logic v, input logic [DW-1:0] xv, input logic c);
        in_valid = v;
        x        = xv;
        clr      = c;
        if (c) model_clear();
        else if (v) model_accept(xv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
        x        = '0;
    endtask

    task automatic start_test();
        put(1'b0, '0, 1'b1);
        put(1'b0, '0, 1'b0);
        y_hist.delete();
        strobe_cyc.delete();
    endtask

    task automatic check_queue_drained(input string name);
        compared = compared + 1;
        if (exp_q.size() != 0) begin
            mismatched = mismatched + 1;
            $display("FAIL %s_missing_strobes: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_hist(input string name, input int idx, input int required);
        compared = compared + 1;
        if (idx >= y_hist.size()) begin
            mismatched = mismatched + 1;
            $display("FAIL %s_y%0d: got no sample, required %0d", name, idx, required);
        end else if (y_hist[idx] !== AW'(required)) begin
            mismatched = mismatched + 1;
            $display("FAIL %s_y%0d: got %0d, required %0d", name, idx, y_hist[idx], required);
        end
    endtask

    task automatic check_intervals(input string name, input int required);
        for (int i = 1; i < strobe_cyc.size(); i++) begin
            compared = compared + 1;
            if (strobe_cyc[i] - strobe_cyc[i-1] != required) begin
                mismatched = mismatched + 1;
                $display("FAIL %s_interval%0d: got %0d, required %0d", name, i,
                         strobe_cyc[i] - strobe_cyc[i-1], required);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; x = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        compared = compared + 3;
        if (y !== '0) begin mismatched++; $display("FAIL reset_y: got %0d, required 0", y); end
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (phase !== 2'd0) begin mismatched++; $display("FAIL reset_phase: got %0d, required 0", phase); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_step();
        start_test();
        for (int i = 0; i < 16; i++) put(1'b1, 12'd1, 1'b0);
        put(1'b0, '0, 1'b0);
        check_hist("step", 0, 4);
        check_hist("step", 1, 56);
        check_hist("step", 2, 220);
        check_hist("step", 3, 560);
        check_intervals("step", 4);
        check_queue_drained("step");
    endtask

    task automatic test_gapped();
        logic [1:0] ph;
        start_test();
        for (int i = 0; i < 16; i++) begin
            put(1'b1, 12'd1, 1'b0);
            ph = phase;
            put(1'b0, 12'd1, 1'b0);
            if (i % 5 == 1) begin
                compared = compared + 1;
                if (phase !== ph) begin
                    mismatched++;
                    $display("FAIL gapped_phase_hold: got %0d, required %0d", phase, ph);
                end
            end
        end
        put(1'b0, '0, 1'b0);
        check_hist("gapped", 0, 4);
        check_hist("gapped", 1, 56);
        check_hist("gapped", 2, 220);
        check_hist("gapped", 3, 560);
        check_intervals("gapped", 8);
        check_queue_drained("gapped");
    endtask

    task automatic test_wrap();
        start_test();
        for (int i = 0; i < 12; i++) put(1'b1, 12'h800, 1'b0);
        put(1'b0, '0, 1'b0);
        check_hist("wrap", 2, 73728);
        check_queue_drained("wrap");
    endtask

    task automatic test_reset_mid();
        start_test();
        for (int i = 0; i < 6; i++) put(1'b1, 12'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        compared = compared + 3;
        if (y !== '0) begin mismatched++; $display("FAIL midreset_y: got %0d, required 0", y); end
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid); end
        if (phase !== 2'd0) begin mismatched++; $display("FAIL midreset_phase: got %0d, required 0", phase); end
        model_clear();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        y_hist.delete();
        strobe_cyc.delete();
        for (int i = 0; i < 8; i++) put(1'b1, 12'd1, 1'b0);
        put(1'b0, '0, 1'b0);
        check_hist("midreset", 0, 4);
        check_hist("midreset", 1, 56);
        check_queue_drained("midreset");
    endtask

    task automatic test_clr();
        start_test();
        for (int i = 0; i < 3; i++) put(1'b1, 12'd1, 1'b0);
        put(1'b1, 12'd1, 1'b1);
        compared = compared + 3;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL clr_out_valid: got %b, required 0", out_valid); end
        if (phase !== 2'd0) begin mismatched++; $display("FAIL clr_phase: got %0d, required 0", phase); end
        if (y !== '0) begin mismatched++; $display("FAIL clr_y: got %0d, required 0", y); end
        for (int i = 0; i < 4; i++) put(1'b1, 12'd1, 1'b0);
        put(1'b0, '0, 1'b0);
        compared = compared + 1;
        if (y_hist.size() != 1) begin
            mismatched++;
            $display("FAIL clr_strobe_count: got %0d, required 1", y_hist.size());
        end
        check_hist("clr", 0, 4);
        check_queue_drained("clr");
    endtask

    // Impulse at each of the R input phases through a bench-side 3-stage
    // comb (D=1); the decimated responses together carry the full gain R^N.
    task automatic test_end_to_end();
        int total;
        total = 0;
        for (int p = 0; p < 4; p++) begin
            int c1_prev, c2_prev, y_prev, c1, c2, c3;
            start_test();
            for (int i = 0; i < 36; i++) put(1'b1, (i == p) ? 12'd1 : 12'd0, 1'b0);
            put(1'b0, '0, 1'b0);
            y_prev = 0; c1_prev = 0; c2_prev = 0;
            foreach (y_hist[j]) begin
                int ys;
                ys      = int'($signed(y_hist[j]));
                c1      = ys - y_prev;
                c2      = c1 - c1_prev;
                c3      = c2 - c2_prev;
                total   = total + c3;
                y_prev  = ys;
                c1_prev = c1;
                c2_prev = c2;
            end
            check_queue_drained("e2e");
        end
        compared = compared + 1;
        if (total != 64) begin
            mismatched++;
            $display("FAIL e2e_gain: got %0d, required 64", total);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        test_reset();
        test_step();
        test_gapped();
        test_wrap();
        test_reset_mid();
        test_clr();
        test_end_to_end();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
